// File: rtl/mem_io_responder_if.sv
// CPU-to-memory bus: byte address, lane-strobed write data, read strobe and
// registered read data. The CPU drives the master side; the responder is the slave.
interface mem_io_responder_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_wstrb, mem_rstrb,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wstrb, mem_rstrb,
        output mem_rdata
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: block RAM with per-lane writes plus an I/O page holding
// the LED register and a prescaled timer with a sticky compare-match flag.
module mem_io_responder #(
    parameter int    MEM_WORDS = 256,
    parameter string INIT_FILE = "",
    parameter int    LED_WIDTH = 8,
    parameter int    PRESCALE  = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_io_responder_if.slave    bus,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 timer_match
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        REG_LED     = 3'd0,
        REG_CTRL    = 3'd1,
        REG_COUNT   = 3'd2,
        REG_COMPARE = 3'd3,
        REG_STATUS  = 3'd4,
        REG_RSVD5   = 3'd5,
        REG_RSVD6   = 3'd6,
        REG_RSVD7   = 3'd7
    } io_reg_e;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++)
            if (strb[i]) result[8*i +: 8] = new_word[8*i +: 8];
        return result;
    endfunction

    logic [31:0] ram [MEM_WORDS];

    // Decode; address bits above the RAM index alias.
    logic          io_sel;
    logic [AW-1:0] ram_idx;
    io_reg_e       io_idx;
    logic          io_wr;

    assign io_sel  = bus.mem_addr[22];
    assign ram_idx = bus.mem_addr[AW+1:2];
    assign io_idx  = io_reg_e'(bus.mem_addr[4:2]);
    assign io_wr   = io_sel && (bus.mem_wstrb != 4'b0000);

    logic wr_led, wr_ctrl, wr_count, wr_compare, status_clr;
    assign wr_led     = io_wr && (io_idx == REG_LED);
    assign wr_ctrl    = io_wr && (io_idx == REG_CTRL) && bus.mem_wstrb[0];
    assign wr_count   = io_wr && (io_idx == REG_COUNT);
    assign wr_compare = io_wr && (io_idx == REG_COMPARE);
    assign status_clr = io_wr && (io_idx == REG_STATUS) && bus.mem_wstrb[0]
                        && bus.mem_wdata[0];

    logic [LED_WIDTH-1:0] led_q;
    logic [1:0]           ctrl_q;
    logic [31:0]          count_q;
    logic [31:0]          compare_q;
    logic                 status_q;
    logic [PW-1:0]        presc_q;
    logic [31:0]          io_rdata_q;
    logic                 rd_ram_q;
    logic [31:0]          ram_rdata_q;

    logic        tick;
    logic [31:0] count_inc;
    logic        match_set;
    logic [31:0] led_next;

    assign tick      = ctrl_q[0] && (presc_q == PRESC_LAST);
    assign count_inc = count_q + 32'd1;
    // A COUNT write cancels the increment, so it can never raise the flag.
    assign match_set = tick && !wr_count && (count_inc == compare_q);
    assign led_next  = merge_lanes(32'(led_q), bus.mem_wdata, bus.mem_wstrb);

    logic [31:0] io_read;
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        io_read = '0;
        case (io_idx)
            REG_LED:     io_read = 32'(led_q);
            REG_CTRL:    io_read = {30'd0, ctrl_q};
            REG_COUNT:   io_read = count_q;
            REG_COMPARE: io_read = compare_q;
            REG_STATUS:  io_read = {31'd0, status_q};
            default:     io_read = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q      <= '0;
            ctrl_q     <= '0;
            count_q    <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            status_q   <= 1'b0;
            presc_q    <= '0;
            io_rdata_q <= '0;
            rd_ram_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every read
            // below sees the pre-edge value (read-first, old CTRL/COMPARE for the timer).
            if (wr_led)     led_q     <= led_next[LED_WIDTH-1:0];
            if (wr_ctrl)    ctrl_q    <= bus.mem_wdata[1:0];
            if (wr_compare) compare_q <= merge_lanes(compare_q, bus.mem_wdata, bus.mem_wstrb);

            if (wr_count) begin
                count_q <= merge_lanes(count_q, bus.mem_wdata, bus.mem_wstrb);
                presc_q <= '0;
            end else if (ctrl_q[0]) begin
                presc_q <= tick ? '0 : presc_q + PW'(1);
                if (tick) count_q <= count_inc;
            end

            if (match_set)       status_q <= 1'b1;
            else if (status_clr) status_q <= 1'b0;

            if (bus.mem_rstrb) begin
                rd_ram_q <= !io_sel;
                if (io_sel) io_rdata_q <= io_read;
            end
        end
    end

    // NOTE: the RAM and its read register have no reset, so they map onto block RAM
    // and keep their contents across rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (!io_sel && bus.mem_wstrb[i])
                ram[ram_idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        if (bus.mem_rstrb && !io_sel)
            ram_rdata_q <= ram[ram_idx];
    end

    assign bus.mem_rdata = rd_ram_q ? ram_rdata_q : io_rdata_q;
    assign leds          = led_q;
    assign timer_match   = status_q & ctrl_q[1];

endmodule
